button_conditioner: RTL and testbench

- Conditions the raw active-low push-button before it reaches the VGA/game top level (vga_top); sits directly upstream of it.
- Synchronises the button to HCLK, debounces it, and produces a clean level plus single-cycle event pulses.
- Events: press, release, long-press, and auto-repeat while held.
- The game logic consumes the pulses to step Pac-Man movement or menu selection.

---
 rtl/pacman_pkg.sv | 27 ++
 rtl/sync_ff.sv | 25 ++
 rtl/button_conditioner.sv | 150 +++++++++++++++
 tb/tb_button_conditioner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and default timing constants for the Pac-Man game input path.
package pacman_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned CYCLES_PER_MS       = CLK_HZ / 1000;
  localparam int unsigned BTN_DEBOUNCE_CYCLES = CYCLES_PER_MS;        // 1 ms
  localparam int unsigned BTN_LONG_CYCLES     = 500 * CYCLES_PER_MS;  // 0.5 s
  localparam int unsigned BTN_REPEAT_CYCLES   = 100 * CYCLES_PER_MS;  // 0.1 s

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG,
    REL_DB
  } btn_state_t;

  // Debounced level plus the four single-cycle button events.
  typedef struct packed {
    logic pressed;
    logic press_p;
    logic release_p;
    logic long_p;
    logic repeat_p;
  } btn_evt_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage synchroniser for asynchronous inputs, with a configurable reset value.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  // Shift the raw input through the flop chain; reset loads the idle value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronises, debounces and decodes the active-low push-button into a clean
// level plus press/release/long/repeat pulses for the game logic.
module button_conditioner
  import pacman_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = BTN_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = BTN_REPEAT_CYCLES
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_n;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  logic             long_flag, long_flag_nxt;
  btn_evt_t         evt_q, evt_nxt;
  btn_evt_t         out_q;

  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .d    (button),
    .q    (sync_n)
  );

  // Next-state, counter and event decode; the FSM always leaves a state at
  // terminal count, so counters never need to wrap.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    rcnt_nxt          = rcnt;
    long_flag_nxt     = long_flag;
    evt_nxt           = '0;
    evt_nxt.pressed   = evt_q.pressed;
    case (state)
      IDLE: begin
        if (!sync_n) begin
          state_nxt = PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      PRESS_DB: begin
        if (sync_n) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt       = HELD;
          cnt_nxt         = '0;
          evt_nxt.pressed = 1'b1;
          evt_nxt.press_p = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (sync_n) begin
          state_nxt = REL_DB;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt      = LONG;
          rcnt_nxt       = '0;
          long_flag_nxt  = 1'b1;
          evt_nxt.long_p = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      LONG: begin
        if (sync_n) begin
          state_nxt = REL_DB;
          cnt_nxt   = '0;
        end else if (rcnt == REP_LAST) begin
          rcnt_nxt         = '0;
          evt_nxt.repeat_p = 1'b1;
        end else begin
          rcnt_nxt = rcnt + CNT_ONE;
        end
      end
      REL_DB: begin
        if (!sync_n) begin
          state_nxt = long_flag ? LONG : HELD;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt         = IDLE;
          long_flag_nxt     = 1'b0;
          evt_nxt.pressed   = 1'b0;
          evt_nxt.release_p = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, counters and decoded events.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      long_flag <= 1'b0;
      evt_q     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rcnt      <= rcnt_nxt;
      long_flag <= long_flag_nxt;
      evt_q     <= evt_nxt;
    end
  end

  // Output register stage: ports come straight from flops and the pulse
  // latency lands at SYNC_STAGES+DEBOUNCE_CYCLES+1 edges.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      out_q <= '0;
    end else begin
      out_q <= evt_q;
    end
  end

  assign pressed       = out_q.pressed;
  assign press_pulse   = out_q.press_p;
  assign release_pulse = out_q.release_p;
  assign long_pulse    = out_q.long_p;
  assign repeat_pulse  = out_q.repeat_p;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with short timing values.
module tb_button_conditioner;

  logic HCLK;
  logic HRESETn;
  logic button;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic [4:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  int edge_cnt = 0;
  int n_press = 0, n_release = 0, n_long = 0, n_repeat = 0, n_multi = 0;
  int t_press = -1, t_release = -1, t_long = -1, t_rep = -1, t_rep_prev = -1;
  int s_press, s_release, s_long, s_repeat;
  int a, r;

  button_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .button       (button),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  assign outs = {pressed, press_pulse, release_pulse, long_pulse, repeat_pulse};

  // 20 ns clock: posedges at 10, 30, 50 ...
  initial HCLK = 1'b0;
  always #10 HCLK = ~HCLK;

  // Count rising edges so pulse timestamps can be compared to edge numbers.
  always @(posedge HCLK) edge_cnt <= edge_cnt + 1;

  // Record every pulse and the edge after which it became visible.
  always @(negedge HCLK) begin
    if (press_pulse === 1'b1) begin n_press++; t_press = edge_cnt; end
    if (release_pulse === 1'b1) begin n_release++; t_release = edge_cnt; end
    if (long_pulse === 1'b1) begin n_long++; t_long = edge_cnt; end
    if (repeat_pulse === 1'b1) begin
      n_repeat++;
      t_rep_prev = t_rep;
      t_rep = edge_cnt;
    end
    if ($countones({press_pulse === 1'b1, release_pulse === 1'b1,
                    long_pulse === 1'b1, repeat_pulse === 1'b1}) > 1)
      n_multi++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge HCLK);
      #2;
    end
  endtask

  task automatic take_snapshot();
    s_press   = n_press;
    s_release = n_release;
    s_long    = n_long;
    s_repeat  = n_repeat;
  endtask

  initial begin
    // Reset values with the button undriven
    HRESETn = 1'b0;
    button  = 1'bx;
    #5;
    check_output("rst_outputs_t0", outs, 0);
    step(3);
    check_output("rst_outputs_clocked", outs, 0);
    button  = 1'b1;
    HRESETn = 1'b1;
    take_snapshot();
    step(50);
    check_output("idle_no_press", n_press - s_press, 0);
    check_output("idle_no_release", n_release - s_release, 0);
    check_output("idle_no_long_repeat", (n_long - s_long) + (n_repeat - s_repeat), 0);
    check_output("idle_pressed", pressed, 0);

    // Clean press and release
    take_snapshot();
    button = 1'b0;
    a = edge_cnt + 1;
    step(7);
    check_output("press_not_early", pressed, 0);
    step(1);
    check_output("press_pulse_rise", press_pulse, 1);
    check_output("pressed_set", pressed, 1);
    step(2);
    check_output("press_once", n_press - s_press, 1);
    check_output("press_latency", t_press, a + 7);
    check_output("pressed_held", pressed, 1);
    button = 1'b0;
    r = 0;
    button = 1'b1;
    r = edge_cnt + 1;
    step(7);
    check_output("pressed_during_rel_db", pressed, 1);
    check_output("release_not_early", n_release - s_release, 0);
    step(1);
    check_output("release_pulse_rise", release_pulse, 1);
    check_output("pressed_cleared", pressed, 0);
    step(4);
    check_output("release_once", n_release - s_release, 1);
    check_output("release_latency", t_release, r + 7);

    // Bounce rejection
    take_snapshot();
    button = 1'b0; step(2);
    button = 1'b1; step(1);
    button = 1'b0; step(2);
    button = 1'b1; step(20);
    check_output("bounce_no_press", n_press - s_press, 0);
    check_output("bounce_outputs", outs, 0);

    // Long press, repeats, and a release that lands on a repeat slot
    take_snapshot();
    button = 1'b0;
    a = edge_cnt + 1;
    step(64);
    check_output("long_press_count", n_press - s_press, 1);
    check_output("long_press_latency", t_press, a + 7);
    check_output("long_count", n_long - s_long, 1);
    check_output("long_latency", t_long, a + 27);
    check_output("repeat_count", n_repeat - s_repeat, 4);
    check_output("repeat_prev_time", t_rep_prev, a + 51);
    check_output("repeat_last_time", t_rep, a + 59);
    button = 1'b1;
    r = edge_cnt + 1;
    step(12);
    check_output("no_repeat_on_release", n_repeat - s_repeat, 4);
    check_output("long_release_once", n_release - s_release, 1);
    check_output("long_release_latency", t_release, r + 7);
    check_output("long_release_pressed", pressed, 0);
    check_output("no_coincident_pulses", n_multi, 0);

    // Release glitch while HELD
    take_snapshot();
    button = 1'b0;
    step(12);
    check_output("glitch_pressed_before", pressed, 1);
    button = 1'b1; step(2);
    button = 1'b0; step(8);
    check_output("glitch_no_release", n_release - s_release, 0);
    check_output("glitch_pressed_kept", pressed, 1);
    button = 1'b1;
    r = edge_cnt + 1;
    step(10);
    check_output("glitch_release_once", n_release - s_release, 1);
    check_output("glitch_release_latency", t_release, r + 7);
    check_output("glitch_pressed_cleared", pressed, 0);
    check_output("glitch_no_long", n_long - s_long, 0);

    // Reset while in LONG, button still held afterwards
    take_snapshot();
    button = 1'b0;
    step(30);
    check_output("rst_mid_long_reached", n_long - s_long, 1);
    check_output("rst_mid_pressed_before", pressed, 1);
    HRESETn = 1'b0;
    #1;
    check_output("rst_mid_async_clear", outs, 0);
    step(3);
    HRESETn = 1'b1;
    a = edge_cnt + 1;
    step(10);
    check_output("rst_mid_fresh_press", n_press - s_press, 2);
    check_output("rst_mid_press_latency", t_press, a + 7);
    check_output("rst_mid_no_release", n_release - s_release, 0);
    check_output("rst_mid_pressed", pressed, 1);

    button = 1'b1;
    step(12);
    check_output("final_no_coincident", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
